// File: rtl/char_writer_pkg.sv
// Shared constants, control codes and FSM encoding for the character writer.
package char_writer_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 24;
  localparam int unsigned ADDR_W = 11;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_DEL = 8'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_CTRL,
    ST_CLR_ROW,
    ST_CLR_ALL
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_SP) && (b < CH_DEL);
  endfunction

endpackage

// File: rtl/cell_addr.sv
// Maps a logical row (scroll base + offset, wrapped at ROWS) and column to a buffer address.
module cell_addr #(
  parameter int unsigned COLS   = char_writer_pkg::COLS,
  parameter int unsigned ROWS   = char_writer_pkg::ROWS,
  parameter int unsigned ADDR_W = char_writer_pkg::ADDR_W
) (
  input  logic [4:0]        base,
  input  logic [4:0]        offset,
  input  logic [6:0]        col,
  output logic [ADDR_W-1:0] addr
);

  logic [5:0] sum;
  logic [4:0] phys;

  assign sum  = {1'b0, base} + {1'b0, offset};
  assign phys = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];

  generate
    if (COLS == 80) begin : g_shift
      // phys*80 as phys*64 + phys*16
      assign addr = ADDR_W'({phys, 6'b0}) + ADDR_W'({phys, 4'b0}) + ADDR_W'(col);
    end else begin : g_mul
      assign addr = ADDR_W'(phys * COLS) + ADDR_W'(col);
    end
  endgenerate

endmodule

// File: rtl/char_writer.sv
// Byte-stream interpreter that owns the cursor, scroll offset and all buffer writes,
// issuing writes only while the raster is blanking.
module char_writer #(
  parameter int unsigned COLS   = char_writer_pkg::COLS,
  parameter int unsigned ROWS   = char_writer_pkg::ROWS,
  parameter int unsigned ADDR_W = char_writer_pkg::ADDR_W
) (
  input  logic              px_clk,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              blank,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_din,
  output logic              buf_wen,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic [4:0]        first_row,
  output logic              busy
);
  import char_writer_pkg::*;

  localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_END  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ALL_END  = ADDR_W'(COLS * ROWS - 1);

  state_t            state, state_n;
  logic [6:0]        col, col_n;
  logic [4:0]        row, row_n;
  logic [4:0]        top, top_n;
  logic [4:0]        crow, crow_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [7:0]        ch, ch_n;
  logic              do_lf;

  logic [4:0]        ca_base, ca_off;
  logic [6:0]        ca_col;
  logic [ADDR_W-1:0] ca_addr;

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
      top   <= '0;
      crow  <= '0;
      cnt   <= '0;
      ch    <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      top   <= top_n;
      crow  <= crow_n;
      cnt   <= cnt_n;
      ch    <= ch_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    top_n   = top;
    crow_n  = crow;
    cnt_n   = cnt;
    ch_n    = ch;
    do_lf   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            ch_n    = in_data;
            state_n = ST_PUT;
          end else begin
            state_n = ST_CTRL;
            case (in_data)
              CH_LF: do_lf = 1'b1;
              CH_CR: col_n = '0;
              CH_BS: if (col != '0) col_n = col - 7'd1;
              CH_FF: begin
                col_n   = '0;
                row_n   = '0;
                top_n   = '0;
                cnt_n   = '0;
                state_n = ST_CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      ST_PUT: begin
        if (blank) begin
          state_n = ST_IDLE;
          if (col == COL_LAST) begin
            col_n = '0;
            do_lf = 1'b1;
          end else begin
            col_n = col + 7'd1;
          end
        end
      end
      ST_CTRL: state_n = ST_IDLE;
      ST_CLR_ROW: begin
        if (blank) begin
          if (cnt == ROW_END) state_n = ST_IDLE;
          else                cnt_n   = cnt + 1'b1;
        end
      end
      ST_CLR_ALL: begin
        if (blank) begin
          if (cnt == ALL_END) state_n = ST_IDLE;
          else                cnt_n   = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // LF at the bottom scrolls: the old top row becomes the new bottom row and is blanked
    if (do_lf) begin
      if (row != ROW_LAST) begin
        row_n = row + 5'd1;
      end else begin
        top_n   = (top == ROW_LAST) ? 5'd0 : top + 5'd1;
        crow_n  = top;
        cnt_n   = '0;
        state_n = ST_CLR_ROW;
      end
    end
  end

  assign ca_base = (state == ST_CLR_ROW) ? crow : top;
  assign ca_off  = (state == ST_CLR_ROW) ? 5'd0 : row;
  assign ca_col  = (state == ST_CLR_ROW) ? cnt[6:0] : col;

  cell_addr #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cell_addr (
    .base   (ca_base),
    .offset (ca_off),
    .col    (ca_col),
    .addr   (ca_addr)
  );

  always_comb begin
    buf_wen  = 1'b0;
    buf_addr = '0;
    buf_din  = '0;
    case (state)
      ST_PUT: begin
        buf_wen  = blank;
        buf_addr = ca_addr;
        buf_din  = ch;
      end
      ST_CLR_ROW: begin
        buf_wen  = blank;
        buf_addr = ca_addr;
        buf_din  = CH_SP;
      end
      ST_CLR_ALL: begin
        buf_wen  = blank;
        buf_addr = cnt;
        buf_din  = CH_SP;
      end
      default: ;
    endcase
  end

  assign in_ready   = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign cursor_col = col;
  assign cursor_row = row;
  assign first_row  = top;

endmodule
